// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy input blocks: FSM state encoding,
// default timing constants and a counter-width helper.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    FLAP     = 2'd2,
    COOLDOWN = 2'd3
  } flap_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned COOLDOWN_TICKS_DEF  = 2;
  localparam int unsigned REPEAT_TICKS_DEF    = 8;

  // Bits needed to hold 0..max_val (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low pushbutton; emits a one-cycle
// press pulse on each debounced release->press transition.
module key_debounce
  import flappy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             stable_prev;
  logic [CNT_W-1:0] cnt;

  // Counter only advances while the synced level disagrees with the accepted one
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      stable      <= 1'b1;
      stable_prev <= 1'b1;
      press       <= 1'b0;
      cnt         <= '0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      stable_prev <= stable;
      press       <= stable_prev & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/flap_input_ctrl.sv
// Turns a debounced key into tick-aligned, rate-limited flap requests.
// Optional AUTO_REPEAT_EN: a held key re-fires a press every REPEAT_TICKS idle ticks.
module flap_input_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned COOLDOWN_TICKS  = COOLDOWN_TICKS_DEF,
  parameter int unsigned REPEAT_TICKS    = REPEAT_TICKS_DEF,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_n,
  input  logic               game_tick,
  input  logic               freeze,
  output logic               flap,
  output logic               busy,
  output logic [COUNT_W-1:0] flap_count
);

  localparam int unsigned CD_W = cnt_width(COOLDOWN_TICKS);

  flap_state_e        state;
  flap_state_e        state_nxt;
  logic [CD_W-1:0]    cd;
  logic [CD_W-1:0]    cd_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               key_stable;
  logic               key_press;
  logic               press_c;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .stable(key_stable),
    .press (key_press)
  );

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = cnt_width(REPEAT_TICKS);

  logic [RPT_W-1:0] rpt;
  logic             auto_press_c;

  assign auto_press_c = (state == IDLE) && !key_stable && !freeze && game_tick &&
                        (rpt == RPT_W'(REPEAT_TICKS - 1));

  // Counts idle ticks while the key is held; any other condition clears it
  always_ff @(posedge clk) begin
    if (rst || (state != IDLE) || key_stable || freeze || auto_press_c) begin
      rpt <= '0;
    end else if (game_tick) begin
      rpt <= rpt + RPT_W'(1);
    end
  end

  assign press_c = key_press | auto_press_c;
`else
  logic unused_cfg;
  assign unused_cfg = ^{key_stable, 32'(REPEAT_TICKS)};
  assign press_c    = key_press;
`endif

  // State and output registers; flap and busy follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cd         <= '0;
      flap       <= 1'b0;
      busy       <= 1'b0;
      flap_count <= '0;
    end else begin
      state      <= state_nxt;
      cd         <= cd_nxt;
      flap       <= (state_nxt == FLAP);
      busy       <= (state_nxt != IDLE);
      flap_count <= count_nxt;
    end
  end

  // Next-state logic; freeze wins over press and game_tick everywhere
  always_comb begin
    state_nxt = state;
    cd_nxt    = cd;
    count_nxt = flap_count;
    case (state)
      IDLE: begin
        if (press_c && !freeze) state_nxt = PENDING;
      end
      PENDING: begin
        if (freeze) begin
          state_nxt = IDLE;
        end else if (game_tick) begin
          state_nxt = FLAP;
          if (flap_count != '1) count_nxt = flap_count + COUNT_W'(1);
        end
      end
      FLAP: begin
        if (freeze) begin
          state_nxt = IDLE;
        end else if (game_tick) begin
          if (COOLDOWN_TICKS == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = COOLDOWN;
            cd_nxt    = CD_W'(COOLDOWN_TICKS);
          end
        end
      end
      COOLDOWN: begin
        if (freeze) begin
          state_nxt = IDLE;
          cd_nxt    = '0;
        end else if (game_tick) begin
          if (cd <= CD_W'(1)) begin
            state_nxt = IDLE;
            cd_nxt    = '0;
          end else begin
            cd_nxt = cd - CD_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flap_input_ctrl.sv
// Directed bench for flap_input_ctrl: DEBOUNCE_CYCLES=4, COOLDOWN_TICKS=2,
// REPEAT_TICKS=3, game_tick every 10 clks. A 2-bit-count copy covers saturation.
module tb_flap_input_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic        game_tick = 1'b0;
  logic        freeze = 1'b0;
  logic        flap;
  logic        busy;
  logic [15:0] flap_count;
  logic        sat_flap;
  logic        sat_busy;
  logic [1:0]  sat_count;

  int n_cmp = 0;
  int n_err = 0;
  int clk_n = 0;
  int rises = 0;
  int width = 0;
  int last_width = 0;
  logic flap_prev = 1'b0;

  typedef struct {
    int   k;
    logic key_n;
    logic freeze;
    logic exp_flap;
    logic exp_busy;
    int   exp_count;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  flap_input_ctrl #(
    .DEBOUNCE_CYCLES(4), .COOLDOWN_TICKS(2), .REPEAT_TICKS(3), .COUNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .game_tick(game_tick), .freeze(freeze),
    .flap(flap), .busy(busy), .flap_count(flap_count)
  );

  flap_input_ctrl #(
    .DEBOUNCE_CYCLES(4), .COOLDOWN_TICKS(2), .REPEAT_TICKS(3), .COUNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .key_n(key_n), .game_tick(game_tick), .freeze(freeze),
    .flap(sat_flap), .busy(sat_busy), .flap_count(sat_count)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (clk_n=%0d)", name, got, exp, clk_n);
    end
  endtask

  // Advance one clock; on return outputs reflect posedge clk_n-1 and
  // game_tick is set up for posedge clk_n.
  task automatic tick_clk();
    @(negedge clk);
    if (flap && !flap_prev) begin
      rises++;
      width = 1;
    end else if (flap) begin
      width++;
    end else if (flap_prev) begin
      last_width = width;
    end
    flap_prev = flap;
    clk_n++;
    game_tick = (clk_n % 10 == 0);
  endtask

  task automatic run_to(input int k);
    while (clk_n < k) tick_clk();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    key_n  = 1'b1;
    freeze = 1'b0;
    repeat (3) tick_clk();
    rst        = 1'b0;
    clk_n      = 0;
    game_tick  = 1'b1;
    rises      = 0;
    width      = 0;
    last_width = 0;
    flap_prev  = 1'b0;
  endtask

  initial begin
    int exp_auto;

    // Clean press held 50 clks: {k, key_n, freeze, flap, busy, count}
    vecs[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{8,   1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{9,   1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3]  = '{10,  1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[4]  = '{11,  1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[5]  = '{20,  1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[6]  = '{21,  1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{40,  1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[8]  = '{41,  1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{51,  1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{100, 1'b1, 1'b0, 1'b0, 1'b0, 1};

    // Reset state and idle quiet period
    do_reset();
    chk("reset_flap", int'(flap), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(flap_count), 0);
    run_to(100);
    chk("idle_rises", rises, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_count", int'(flap_count), 0);

    // Clean press, table driven
    do_reset();
    for (int i = 0; i < 11; i++) begin
      run_to(vecs[i].k);
      chk($sformatf("vec%0d_flap", i), int'(flap), int'(vecs[i].exp_flap));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_count", i), int'(flap_count), vecs[i].exp_count);
      key_n  = vecs[i].key_n;
      freeze = vecs[i].freeze;
    end
    chk("clean_rises", rises, 1);
    chk("clean_width", last_width, 10);

    // Bouncing key; debounced press coincides with a tick and must go PENDING only
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      run_to(k);
      key_n = (((k - 1) / 2) % 2 == 1);
    end
    run_to(13);
    key_n = 1'b0;
    run_to(20);
    chk("bounce_pre_busy", int'(busy), 0);
    run_to(21);
    chk("bounce_same_tick_busy", int'(busy), 1);
    chk("bounce_same_tick_flap", int'(flap), 0);
    run_to(31);
    chk("bounce_flap_high", int'(flap), 1);
    run_to(70);
    key_n = 1'b1;
    run_to(100);
    chk("bounce_rises", rises, 1);
    chk("bounce_count", int'(flap_count), 1);
    chk("bounce_width", last_width, 10);
    chk("bounce_busy", int'(busy), 0);

    // Presses during FLAP and COOLDOWN are dropped; later press flaps again
    do_reset();
    run_to(4);  key_n = 1'b0;
    run_to(12); key_n = 1'b1;
    run_to(18); key_n = 1'b0;
    run_to(26); key_n = 1'b1;
    run_to(33); key_n = 1'b0;
    run_to(41); key_n = 1'b1;
    run_to(55);
    chk("drop_rises", rises, 1);
    chk("drop_count", int'(flap_count), 1);
    chk("drop_busy", int'(busy), 0);
    key_n = 1'b0;
    run_to(63); key_n = 1'b1;
    run_to(120);
    chk("rearm_rises", rises, 2);
    chk("rearm_count", int'(flap_count), 2);
    chk("rearm_width", last_width, 10);

    // freeze in PENDING, mid-FLAP, and presses while frozen
    do_reset();
    run_to(4); key_n = 1'b0;
    run_to(12);
    chk("frz_pending_busy", int'(busy), 1);
    run_to(13); freeze = 1'b1;
    run_to(14);
    chk("frz_pending_idle", int'(busy), 0);
    key_n = 1'b1;
    run_to(25);
    chk("frz_pending_flap", int'(flap), 0);
    chk("frz_pending_count", int'(flap_count), 0);
    freeze = 1'b0;
    run_to(30); key_n = 1'b0;
    run_to(45);
    chk("frz_mid_flap_before", int'(flap), 1);
    freeze = 1'b1;
    run_to(46);
    chk("frz_mid_flap_after", int'(flap), 0);
    chk("frz_mid_busy", int'(busy), 0);
    chk("frz_mid_count", int'(flap_count), 1);
    run_to(47); key_n = 1'b1;
    run_to(60); key_n = 1'b0;
    run_to(80);
    chk("frz_press_busy", int'(busy), 0);
    chk("frz_press_count", int'(flap_count), 1);
    freeze = 1'b0;
    run_to(110);
    chk("frz_held_count", int'(flap_count), 1);
    chk("frz_held_rises", rises, 1);

    // Key held 200 clks: single flap, or auto-repeat when enabled
    do_reset();
    run_to(1);   key_n = 1'b0;
    run_to(201); key_n = 1'b1;
    run_to(300);
`ifdef AUTO_REPEAT_EN
    exp_auto = 3;
`else
    exp_auto = 1;
`endif
    chk("hold_rises", rises, exp_auto);
    chk("hold_count", int'(flap_count), exp_auto);
    chk("hold_busy", int'(busy), 0);

    // Five separate presses: 16-bit count reaches 5, 2-bit count saturates at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_to(1 + 60 * i);  key_n = 1'b0;
      run_to(21 + 60 * i); key_n = 1'b1;
    end
    run_to(320);
    chk("sat_main_count", int'(flap_count), 5);
    chk("sat_small_count", int'(sat_count), 3);
    chk("sat_small_busy", int'(sat_busy), 0);
    chk("sat_small_flap", int'(sat_flap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
